adc_sample_averager: RTL and testbench
======================================

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1000: clk_in cycles between consecutive trigger starts (min 64).
REQ-002 Parameter AVG_LOG2, default 2: samples per average = 2^AVG_LOG2 (range 0..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 2000: conversion watchdog limit (used only with ADC_TIMEOUT_EN).
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high = run periodic acquisition.
REQ-007 adc_cs_n  input  1  driver chip-select; low = conversion in progress.
REQ-008 adc_data  input  16  driver shift-register frame; bits [11:0] = result.
REQ-009 start_convert  output  1  active-low conversion request to driver.
REQ-010 avg_out  output  12  latest averaged result.
REQ-011 avg_valid  output  1  one-cycle pulse when avg_out updates.
REQ-012 overrun  output  1  sticky; period expired before conversion completed.
REQ-013 timeout_err  output  1  sticky; conversion watchdog fired.

Function
REQ-014 States SHALL be IDLE, TRIGGER, WAIT_BUSY, WAIT_DONE, ACCUM, OUTPUT.
REQ-015 IDLE -> TRIGGER when enable=1, adc_cs_n=1 and period counter expired (or first trigger after enable rises).
REQ-016 TRIGGER SHALL drive start_convert=0 one cycle, reload period counter to SAMPLE_PERIOD-1, go to WAIT_BUSY.
REQ-017 WAIT_BUSY SHALL hold start_convert=0 until adc_cs_n=0 sampled, then release start_convert=1 and go to WAIT_DONE.
REQ-018 WAIT_DONE -> ACCUM on adc_cs_n rising edge (registered previous value 0, current 1).
REQ-019 ACCUM SHALL add zero-extended adc_data[11:0] (sampled that cycle) into a (12+AVG_LOG2)-bit accumulator and increment sample counter; bits [15:12] ignored.
REQ-020 After 2^AVG_LOG2 samples ACCUM -> OUTPUT, else -> IDLE.
REQ-021 OUTPUT SHALL load avg_out = accumulator >> AVG_LOG2 (truncating), pulse avg_valid one cycle, clear accumulator and sample counter, go to IDLE.
REQ-022 Period counter SHALL decrement every cycle independent of state, saturate at 0.
REQ-023 If counter reaches 0 while in WAIT_BUSY or WAIT_DONE, overrun SHALL set; next trigger deferred to first IDLE cycle (no trigger dropped silently).
REQ-024 enable falling mid-conversion: current conversion completes, sample discarded, accumulator and sample counter cleared, return IDLE; avg_valid not pulsed.
REQ-025 Latency: avg_valid SHALL rise exactly 2 cycles after the adc_cs_n rising edge completing the final sample.
REQ-026 start_convert SHALL never be 0 while in IDLE, ACCUM or OUTPUT.

Reset
REQ-027 On reset=1 at a clk_in edge: state IDLE, start_convert=1, avg_out=0, avg_valid=0, overrun=0, timeout_err=0, accumulator, sample and period counters=0.
REQ-028 Reset mid-conversion SHALL abandon the sample; no new trigger until adc_cs_n is seen 1 in IDLE.

Configuration
REQ-029 Macro ADC_TIMEOUT_EN defined: watchdog counts cycles in WAIT_BUSY+WAIT_DONE; reaching TIMEOUT_CYCLES sets timeout_err, releases start_convert=1, clears accumulator and sample counter, returns IDLE.
REQ-030 ADC_TIMEOUT_EN undefined: no watchdog logic; WAIT_BUSY/WAIT_DONE wait indefinitely; timeout_err tied 0.

Verification (AVG_LOG2=2, SAMPLE_PERIOD=1000, TIMEOUT_CYCLES=2000, driver model converting in 600 cycles)
REQ-031 Frames 0x0100,0x0102,0x0104,0x0106 -> avg_out=0x103, single avg_valid pulse, triggers 1000 cycles apart, overrun=0.
REQ-032 Frames 0xF0FF x4 -> avg_out=0x0FF; frames 0x0FFF x4 -> avg_out=0xFFF, no accumulator overflow.
REQ-033 Driver conversion lengthened to 1200 cycles -> overrun=1, next start_convert low on first IDLE cycle after completion.
REQ-034 Reset at cycle 300 of second conversion -> all outputs at reset values next cycle; next four fresh frames 0x0010 x4 -> avg_out=0x010.
REQ-035 ADC_TIMEOUT_EN defined, adc_cs_n held 1 -> timeout_err=1 after 2000 cycles, start_convert=1; undefined -> start_convert stays 0, timeout_err=0.
REQ-036 enable dropped during third sample -> no avg_valid; re-enable with 4 frames 0x0200 -> avg_out=0x200.

Source files
------------

// File: rtl/adc_sample_averager.sv
// Periodic ADC trigger/accumulate/average controller; averages 2^AVG_LOG2 12-bit samples.
// Optional conversion watchdog enabled by defining ADC_TIMEOUT_EN.
module adc_sample_averager #(
  parameter int unsigned SAMPLE_PERIOD  = 1000,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_cs_n,
  input  logic [15:0] adc_data,
  output logic        start_convert,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PER_W-1:0] PERIOD_RELOAD = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_BUSY,
    WAIT_DONE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   sample_cnt;
  logic [PER_W-1:0]   period_cnt;
  logic               cs_prev;
  logic               enable_prev;
  logic               first_pending;
  logic               discard;
  logic               period_expired;
  logic               in_wait;
  logic               unused_frame_bits;

  assign acc_sum           = acc + ACC_W'(adc_data[11:0]);
  assign in_wait           = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign unused_frame_bits = ^adc_data[15:12];

  // The reload lands one cycle after the IDLE decision, so expiry is taken at 1
  // to keep trigger starts exactly SAMPLE_PERIOD cycles apart.
  assign period_expired = (period_cnt <= PER_W'(1));

`ifdef ADC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            timeout_flag;

  assign wd_fire     = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_flag;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= IDLE;
      start_convert <= 1'b1;
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      overrun       <= 1'b0;
      acc           <= '0;
      sample_cnt    <= '0;
      period_cnt    <= '0;
      cs_prev       <= 1'b1;
      enable_prev   <= 1'b0;
      first_pending <= 1'b0;
      discard       <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      wd_cnt        <= '0;
      timeout_flag  <= 1'b0;
`endif
    end else begin
      cs_prev     <= adc_cs_n;
      enable_prev <= enable;
      avg_valid   <= 1'b0;

      if (period_cnt != '0)
        period_cnt <= period_cnt - 1'b1;

      if (!enable)
        first_pending <= 1'b0;
      else if (!enable_prev)
        first_pending <= 1'b1;

      if (in_wait && (period_cnt == '0))
        overrun <= 1'b1;

      // Disable mid-conversion lets the driver finish but throws the sample away.
      if (!enable && (in_wait || state == TRIGGER))
        discard <= 1'b1;

`ifdef ADC_TIMEOUT_EN
      if (in_wait)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
`endif

      case (state)
        IDLE: begin
          if (enable && adc_cs_n && (period_expired || first_pending)) begin
            state         <= TRIGGER;
            start_convert <= 1'b0;
            first_pending <= 1'b0;
            discard       <= 1'b0;
          end
        end
        TRIGGER: begin
          period_cnt <= PERIOD_RELOAD;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!adc_cs_n) begin
            start_convert <= 1'b1;
            state         <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!cs_prev && adc_cs_n)
            state <= ACCUM;
        end
        // The final sample's average is formed here so avg_valid is up during OUTPUT.
        ACCUM: begin
          discard <= 1'b0;
          if (discard || !enable) begin
            acc        <= '0;
            sample_cnt <= '0;
            state      <= IDLE;
          end else if (sample_cnt == LAST_SAMPLE) begin
            avg_out   <= acc_sum[ACC_W-1:AVG_LOG2];
            avg_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + 1'b1;
            state      <= IDLE;
          end
        end
        OUTPUT: begin
          acc        <= '0;
          sample_cnt <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef ADC_TIMEOUT_EN
      if (wd_fire) begin
        timeout_flag  <= 1'b1;
        start_convert <= 1'b1;
        acc           <= '0;
        sample_cnt    <= '0;
        discard       <= 1'b0;
        state         <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager; the initial block also acts as the ADC driver model.
// Build with ADC_TIMEOUT_EN defined to exercise the watchdog branch of the last step.
module tb_adc_sample_averager;

  logic        clk_in;
  logic        reset;
  logic        enable;
  logic        adc_cs_n;
  logic [15:0] adc_data;
  logic        start_convert;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        overrun;
  logic        timeout_err;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  adc_sample_averager #(
    .SAMPLE_PERIOD (1000),
    .AVG_LOG2      (2),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .adc_cs_n     (adc_cs_n),
    .adc_data     (adc_data),
    .start_convert(start_convert),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycle <= cycle + 1;

  initial begin
    #800000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitTrigger(output int trig_at);
    int n;
    bit found;
    n = 0;
    while (start_convert !== 1'b0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    found   = (start_convert === 1'b0);
    trig_at = cycle;
    checkOutput("trigger_seen", 32'(found), 32'd1);
  endtask

  // One full conversion as the driver sees it: wait for the request, hold
  // chip-select low for conv_len cycles, present the frame, release.
  task automatic applyStimulus(input logic [15:0] frame, input int conv_len, input bit last,
                               input bit drop_en, output int trig_at);
    waitTrigger(trig_at);
    adc_cs_n = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("start_released", 32'(start_convert), 32'd1);
    repeat (conv_len / 2) @(negedge clk_in);
    if (drop_en) enable = 1'b0;
    repeat (conv_len - 2 - conv_len / 2) @(negedge clk_in);
    adc_data = frame;
    adc_cs_n = 1'b1;
    @(negedge clk_in);
    checkOutput("valid_early", 32'(avg_valid), 32'd0);
    @(negedge clk_in);
    checkOutput("valid_latency", 32'(avg_valid), 32'(last));
    if (last) begin
      @(negedge clk_in);
      checkOutput("valid_single", 32'(avg_valid), 32'd0);
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    bit any_low;
    bit any_valid;

    reset    = 1'b1;
    enable   = 1'b0;
    adc_cs_n = 1'b1;
    adc_data = 16'h0000;
    repeat (3) @(negedge clk_in);
    checkOutput("rst_start", 32'(start_convert), 32'd1);
    checkOutput("rst_avg", 32'(avg_out), 32'h000);
    checkOutput("rst_valid", 32'(avg_valid), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    @(negedge clk_in);
    enable = 1'b1;

    $display("[TB] ramp frames 0x100..0x106");
    applyStimulus(16'h0100, 600, 1'b0, 1'b0, t0);
    applyStimulus(16'h0102, 600, 1'b0, 1'b0, t1);
    checkOutput("period_1_2", 32'(t1 - t0), 32'd1000);
    applyStimulus(16'h0104, 600, 1'b0, 1'b0, t2);
    applyStimulus(16'h0106, 600, 1'b1, 1'b0, t3);
    checkOutput("period_3_4", 32'(t3 - t2), 32'd1000);
    checkOutput("avg_ramp", 32'(avg_out), 32'h103);
    checkOutput("overrun_clear", 32'(overrun), 32'd0);

    $display("[TB] upper nibble masking and full scale");
    for (int i = 0; i < 4; i++) applyStimulus(16'hF0FF, 600, i == 3, 1'b0, t0);
    checkOutput("avg_masked", 32'(avg_out), 32'h0FF);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0FFF, 600, i == 3, 1'b0, t0);
    checkOutput("avg_full_scale", 32'(avg_out), 32'hFFF);

    $display("[TB] slow conversion");
    applyStimulus(16'h0010, 1200, 1'b0, 1'b0, t0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("idle_start_high", 32'(start_convert), 32'd1);
    @(negedge clk_in);
    checkOutput("retrigger_first_idle", 32'(start_convert), 32'd0);

    $display("[TB] reset mid-conversion");
    adc_cs_n = 1'b0;
    repeat (300) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    checkOutput("mid_rst_start", 32'(start_convert), 32'd1);
    checkOutput("mid_rst_avg", 32'(avg_out), 32'h000);
    checkOutput("mid_rst_valid", 32'(avg_valid), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    checkOutput("mid_rst_timeout", 32'(timeout_err), 32'd0);
    reset   = 1'b0;
    any_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (start_convert === 1'b0) any_low = 1'b1;
    end
    checkOutput("no_trigger_while_busy", 32'(any_low), 32'd0);
    adc_data = 16'h0FFF;
    adc_cs_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(16'h0010, 600, i == 3, 1'b0, t0);
    checkOutput("avg_after_reset", 32'(avg_out), 32'h010);
    checkOutput("overrun_after_reset", 32'(overrun), 32'd0);

    $display("[TB] enable dropped during third sample");
    applyStimulus(16'h0300, 600, 1'b0, 1'b0, t0);
    applyStimulus(16'h0300, 600, 1'b0, 1'b0, t0);
    applyStimulus(16'h0300, 600, 1'b0, 1'b1, t0);
    any_low   = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (start_convert === 1'b0) any_low = 1'b1;
      if (avg_valid === 1'b1) any_valid = 1'b1;
    end
    checkOutput("disabled_no_trigger", 32'(any_low), 32'd0);
    checkOutput("disabled_no_valid", 32'(any_valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(16'h0200, 600, i == 3, 1'b0, t0);
    checkOutput("avg_after_reenable", 32'(avg_out), 32'h200);

    $display("[TB] driver never responds");
    waitTrigger(t0);
    repeat (2000) @(negedge clk_in);
    checkOutput("timeout_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk_in);
`ifdef ADC_TIMEOUT_EN
    checkOutput("timeout_fired", 32'(timeout_err), 32'd1);
    checkOutput("timeout_start_released", 32'(start_convert), 32'd1);
`else
    checkOutput("no_watchdog_err", 32'(timeout_err), 32'd0);
    checkOutput("no_watchdog_start_held", 32'(start_convert), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
